// File: rtl/im_boot_loader.sv
`default_nettype none
// ============================================================================
// im_boot_loader : byte-stream loader that fills the instruction SRAM from
//                  address 0 and holds the core in reset until loading is done
// Revision 1.0
// ============================================================================
module im_boot_loader #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 2 ** (ADDR_W - 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [3:0]        im_w_en,
    output logic [ADDR_W-1:0] im_address,
    output logic [31:0]       im_write_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] c_st_len0  = 3'd0;
    localparam logic [2:0] c_st_len1  = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_write = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;
    localparam logic [2:0] c_st_err   = 3'd5;

    localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [15:0]       r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [15:0]       r_n;
    logic [31:0]       r_write_data;
    logic [ADDR_W-1:0] r_address;

    logic              w_rx_ready;
    logic              w_accept;
    logic [15:0]       w_n_full;
    logic [15:0]       w_idx_inc;
    logic [17:0]       w_addr_full;

    assign w_accept    = rx_valid && w_rx_ready;
    assign w_n_full    = {rx_data, r_n[7:0]};
    assign w_idx_inc   = r_word_idx + 16'd1;
    assign w_addr_full = {w_idx_inc, 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_len0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_len0: begin
                if (w_accept) w_state_next = c_st_len1;
            end
            c_st_len1: begin
                if (w_accept) begin
                    if (w_n_full == 16'd0) begin
                        w_state_next = c_st_done;
                    end else if ({16'd0, w_n_full} > c_max_words) begin
                        w_state_next = c_st_err;
                    end else begin
                        w_state_next = c_st_data;
                    end
                end
            end
            c_st_data: begin
                if (w_accept && (r_byte_cnt == 2'd3)) w_state_next = c_st_write;
            end
            c_st_write: begin
                w_state_next = (w_idx_inc == r_n) ? c_st_done : c_st_data;
            end
            c_st_done:  w_state_next = c_st_done;
            c_st_err:   w_state_next = c_st_err;
            default:    w_state_next = c_st_len0;
        endcase
    end

    // Output decode; cpu_rst also follows rst directly so the core is held during reset
    always_comb begin
        w_rx_ready = 1'b0;
        im_w_en    = 4'b0000;
        cpu_rst    = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            c_st_len0, c_st_len1, c_st_data: begin
                w_rx_ready = 1'b1;
                busy       = 1'b1;
            end
            c_st_write: begin
                im_w_en = 4'b1111;
                busy    = 1'b1;
            end
            c_st_done: begin
                done    = 1'b1;
                cpu_rst = rst;
            end
            c_st_err: begin
                err = 1'b1;
            end
            default: begin
                w_rx_ready = 1'b0;
            end
        endcase
    end

    // Datapath: header capture, little-endian byte lanes, word address advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_idx   <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_n          <= 16'd0;
            r_write_data <= 32'd0;
            r_address    <= '0;
        end else begin
            case (r_state)
                c_st_len0: begin
                    if (w_accept) r_n[7:0] <= rx_data;
                end
                c_st_len1: begin
                    if (w_accept) r_n[15:8] <= rx_data;
                end
                c_st_data: begin
                    if (w_accept) begin
                        r_write_data[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                c_st_write: begin
                    r_word_idx <= w_idx_inc;
                    r_byte_cnt <= 2'd0;
                    r_address  <= ADDR_W'(w_addr_full);
                end
                default: begin
                    r_byte_cnt <= r_byte_cnt;
                end
            endcase
        end
    end

    assign rx_ready      = w_rx_ready;
    assign im_address    = r_address;
    assign im_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_im_boot_loader.sv
`default_nettype none
// ============================================================================
// tb_im_boot_loader : scoreboard bench for the instruction-memory boot loader
// Revision 1.0
// ============================================================================
module tb_im_boot_loader;

    localparam int ADDR_W    = 16;
    localparam int MAX_WORDS = 16384;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic [3:0]        im_w_en;
    logic [ADDR_W-1:0] im_address;
    logic [31:0]       im_write_data;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    im_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .im_w_en       (im_w_en),
        .im_address    (im_address),
        .im_write_data (im_write_data),
        .cpu_rst       (cpu_rst),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] pay_q[$];
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every SRAM write must match the next expected word in order
    always @(negedge clk) begin
        if (mon_en && (im_w_en != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=no write",
                         im_address, im_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_en",   {28'd0, im_w_en}, 32'h0000_000F);
                chk("wr_addr", {16'd0, im_address}, {16'd0, mon_e.addr});
                chk("wr_data", im_write_data, mon_e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  tmo;
        bit  acc;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tmo      = 0;
        forever begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
            if (acc) break;
            tmo++;
            if (tmo > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout byte=0x%0h actual=not accepted required=accepted", b);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_addr",   {16'd0, im_address}, 32'd0);
        chk("rst_data",   im_write_data, 32'd0);
        chk("rst_wen",    {28'd0, im_w_en}, 32'd0);
        chk("rst_ready",  {31'd0, rx_ready}, 32'd1);
        chk("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_busy",   {31'd0, busy}, 32'd1);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_err",    {31'd0, err}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("cpu_rst_during_rst", {31'd0, cpu_rst}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state();
    endtask

    // Reference model: N legal -> word i lands at byte address 4*i; N==0 or legal -> DONE,
    // N > MAX_WORDS -> ERR. Only complete words of the sent payload are expected.
    task automatic load(input logic [15:0] n, input int gmin, input int gmax,
                        input int nbytes, input bit timed, input bit wait_end);
        int  t0;
        int  t_done;
        bit  legal;
        bit  seen;
        legal = (n != 16'd0) && (int'(n) <= MAX_WORDS);
        if (legal) begin
            for (int i = 0; i < nbytes / 4; i++) begin
                exp_q.push_back('{addr: 16'(i * 4), data: pay_q[i]});
            end
        end
        send_byte(n[7:0], $urandom_range(gmax, gmin));
        t0 = cyc;
        send_byte(n[15:8], $urandom_range(gmax, gmin));
        for (int i = 0; i < nbytes; i++) begin
            logic [31:0] w;
            w = pay_q[i / 4];
            send_byte(w[8 * (i % 4) +: 8], $urandom_range(gmax, gmin));
        end
        if (wait_end) begin
            seen = 1'b0;
            t_done = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (done || err) begin
                    seen   = 1'b1;
                    t_done = cyc;
                    break;
                end
            end
            chk("end_reached", {31'd0, seen}, 32'd1);
            if (int'(n) <= MAX_WORDS) begin
                chk("end_done",   {31'd0, done}, 32'd1);
                chk("end_err",    {31'd0, err}, 32'd0);
                chk("end_cpurst", {31'd0, cpu_rst}, 32'd0);
            end else begin
                chk("end_done",   {31'd0, done}, 32'd0);
                chk("end_err",    {31'd0, err}, 32'd1);
                chk("end_cpurst", {31'd0, cpu_rst}, 32'd1);
            end
            chk("end_busy",    {31'd0, busy}, 32'd0);
            chk("end_ready",   {31'd0, rx_ready}, 32'd0);
            chk("end_pending", exp_q.size(), 32'd0);
            if (timed && legal || timed && n == 16'd0) begin
                chk("load_cycles", t_done - t0, 5 * int'(n) + 1);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic extra_bytes(input bit exp_done);
        logic [15:0] a0;
        logic [31:0] d0;
        @(negedge clk);
        a0 = im_address;
        d0 = im_write_data;
        @(posedge clk); #1;
        rx_valid = 1'b1;
        repeat (6) begin
            rx_data = 8'($urandom);
            @(negedge clk);
            chk("extra_ready", {31'd0, rx_ready}, 32'd0);
            chk("extra_done",  {31'd0, done}, {31'd0, exp_done});
            chk("extra_addr",  {16'd0, im_address}, {16'd0, a0});
            chk("extra_data",  im_write_data, d0);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        int n;
        int g;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        check_reset_state();

        // Single instruction, back-to-back bytes
        pay_q = {32'h00A0_0513};
        load(16'd1, 0, 0, 4, 1'b1, 1'b1);
        extra_bytes(1'b1);
        do_reset();

        // Three words with a gap before every byte
        pay_q = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0093};
        load(16'd3, 1, 1, 12, 1'b0, 1'b1);
        do_reset();

        // Empty image
        pay_q.delete();
        load(16'd0, 0, 0, 0, 1'b1, 1'b1);
        extra_bytes(1'b1);
        do_reset();

        // Over-length counts
        load(16'h4001, 0, 0, 0, 1'b0, 1'b1);
        extra_bytes(1'b0);
        do_reset();
        load(16'hFFFF, 0, 2, 0, 1'b0, 1'b1);
        do_reset();

        // Reset in the middle of the second word, then a fresh load
        pay_q = {32'hCAFE_F00D, 32'h5555_AAAA};
        load(16'd2, 0, 0, 6, 1'b0, 1'b0);
        do_reset();
        chk("midrst_pending", exp_q.size(), 32'd0);
        pay_q = {32'h0130_0093};
        load(16'd1, 0, 0, 4, 1'b1, 1'b1);
        do_reset();

        // Randomized loads
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(8, 1);
            g = (it % 2 == 0) ? 0 : 3;
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back($urandom);
            load(16'(n), 0, g, 4 * n, (g == 0), 1'b1);
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
